// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius (Simon) sequencing controller.
package genius_pkg;

  // FSM states; the encodings double as the state code seen by the display logic.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    WAIT_IN  = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  // One colour of the sequence: 0, 1 or 2 (LED / button index).
  typedef logic [1:0] symbol_t;

  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (register bits 7, 5, 4, 3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Only three colours exist, so the fourth LFSR pattern folds onto colour 0.
  function automatic symbol_t lfsr_to_symbol(input logic [1:0] low_bits);
    return (low_bits == 2'd3) ? 2'd0 : low_bits;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/genius_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; advances every cycle and exposes the
// next colour symbol derived from its two low bits.
module genius_lfsr
  import genius_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic    i_clock,
  input  logic    i_reset,
  output symbol_t o_symbol
);

  logic [7:0] r_lfsr;

  // Shift left each cycle, feeding the XOR of the tapped bits into bit 0.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  assign o_symbol = lfsr_to_symbol(r_lfsr[1:0]);

endmodule

// File: rtl/genius_seq_ctrl.sv
// Genius game sequencer: grows a random colour sequence, plays it back on
// the LEDs, then checks the player's presses against it.
module genius_seq_ctrl
  import genius_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter int         SHOW_CYCLES    = 25000000,
  parameter int         GAP_CYCLES     = 12500000,
  parameter int         TIMEOUT_CYCLES = 250000000,
  parameter logic [7:0] SEED           = 8'hA5
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [2:0]                     btn,
  output logic [2:0]                     led_show,
  output logic [$clog2(MAX_LEN+1)-1:0]   level,
  output logic [2:0]                     state_code,
  output logic                           input_ok,
  output logic                           win,
  output logic                           lose
);

  localparam int LW   = $clog2(MAX_LEN + 1);
  localparam int IW   = $clog2(MAX_LEN);
  localparam int TMAX = max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t        r_state, w_state_next;
  logic [LW-1:0] r_level, w_level_next;
  logic [IW-1:0] r_idx, w_idx_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic          r_input_ok, w_input_ok_next;
  logic [2:0]    r_btn_prev;
  logic          r_start_prev;
  logic          w_mem_we;
  symbol_t       r_mem [MAX_LEN];

  symbol_t       w_symbol;
  logic [2:0]    w_btn_edge;
  logic          w_start_edge;
  logic [2:0]    w_expect_btn;
  logic          w_last;
  logic [IW-1:0] w_wr_addr;

  genius_lfsr #(.SEED(SEED)) u_lfsr (
    .i_clock  (clock),
    .i_reset  (reset),
    .o_symbol (w_symbol)
  );

  assign w_btn_edge   = btn & ~r_btn_prev;
  assign w_start_edge = start & ~r_start_prev;
  assign w_expect_btn = 3'b001 << r_mem[r_idx];
  assign w_last       = (LW'(r_idx) == (r_level - LW'(1)));
  // GEN only runs while level < MAX_LEN, so the low bits address the slot.
  assign w_wr_addr    = r_level[IW-1:0];

  // Next-state and datapath decisions for the game FSM.
  always_comb begin
    w_state_next    = r_state;
    w_level_next    = r_level;
    w_idx_next      = r_idx;
    w_timer_next    = r_timer;
    w_input_ok_next = 1'b0;
    w_mem_we        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_state_next = GEN;
          w_level_next = '0;
        end
      end
      GEN: begin
        w_mem_we     = 1'b1;
        w_level_next = r_level + LW'(1);
        w_idx_next   = '0;
        w_timer_next = '0;
        w_state_next = SHOW_ON;
      end
      SHOW_ON: begin
        if (r_timer == TW'(SHOW_CYCLES - 1)) begin
          w_timer_next = '0;
          w_state_next = SHOW_OFF;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      SHOW_OFF: begin
        if (r_timer == TW'(GAP_CYCLES - 1)) begin
          w_timer_next = '0;
          if (w_last) begin
            w_idx_next   = '0;
            w_state_next = WAIT_IN;
          end else begin
            w_idx_next   = r_idx + IW'(1);
            w_state_next = SHOW_ON;
          end
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      WAIT_IN: begin
        // The expected pattern is always one-hot, so a match implies exactly
        // one rising edge; any other non-empty edge set is a loss.
        if (w_btn_edge == w_expect_btn) begin
          w_input_ok_next = 1'b1;
          w_timer_next    = '0;
          if (w_last) begin
            w_state_next = (r_level == LW'(MAX_LEN)) ? WIN : GEN;
          end else begin
            w_idx_next = r_idx + IW'(1);
          end
        end else if (w_btn_edge != 3'b000) begin
          w_state_next = LOSE;
        end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = LOSE;
        end else begin
          w_timer_next = r_timer + TW'(1);
        end
      end
      WIN, LOSE: begin
        if (w_start_edge) begin
          w_state_next = GEN;
          w_level_next = '0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, counters, edge-detect history and the registered ok pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_level      <= '0;
      r_idx        <= '0;
      r_timer      <= '0;
      r_input_ok   <= 1'b0;
      r_btn_prev   <= 3'b000;
      r_start_prev <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_level      <= w_level_next;
      r_idx        <= w_idx_next;
      r_timer      <= w_timer_next;
      r_input_ok   <= w_input_ok_next;
      r_btn_prev   <= btn;
      r_start_prev <= start;
    end
  end

  // Sequence storage; contents are meaningless until written by GEN.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_wr_addr] <= w_symbol;
    end
  end

  assign led_show   = (r_state == SHOW_ON) ? w_expect_btn : 3'b000;
  assign level      = r_level;
  assign state_code = r_state;
  assign input_ok   = r_input_ok;
  assign win        = (r_state == WIN);
  assign lose       = (r_state == LOSE);

endmodule

// File: tb/tb_genius_seq_ctrl.sv
// Directed bench for genius_seq_ctrl with a small game configuration.
module tb_genius_seq_ctrl;

  localparam int MAX_LEN        = 3;
  localparam int SHOW_CYCLES    = 4;
  localparam int GAP_CYCLES     = 2;
  localparam int TIMEOUT_CYCLES = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] btn   = 3'b000;
  logic [2:0] led_show;
  logic [1:0] level;
  logic [2:0] state_code;
  logic       input_ok;
  logic       win;
  logic       lose;

  genius_seq_ctrl #(
    .MAX_LEN        (MAX_LEN),
    .SHOW_CYCLES    (SHOW_CYCLES),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SEED           (8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .btn        (btn),
    .led_show   (led_show),
    .level      (level),
    .state_code (state_code),
    .input_ok   (input_ok),
    .win        (win),
    .lose       (lose)
  );

  always #5 clock = ~clock;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int sym_of(input logic [7:0] v);
    return (v[1:0] == 2'b11) ? 0 : int'(v[1:0]);
  endfunction

  logic [7:0] model_lfsr;
  always @(posedge clock) begin
    if (reset) model_lfsr <= 8'hA5;
    else       model_lfsr <= lfsr_next(model_lfsr);
  end

  int ok_count = 0;
  always @(negedge clock) begin
    if (input_ok === 1'b1) ok_count++;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  int         exp_seq[$];
  logic [2:0] shown[$];
  logic [2:0] prev_shown[$];

  typedef struct {
    string name;
    int    mode;       // 0 correct, 1 wrong colour, 2 no press, 3 two buttons
    int    exp_state;
    int    exp_lose;
    int    exp_ok;
  } corner_t;

  corner_t corners[4];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    btn   = 3'b000;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic press(input logic [2:0] b);
    btn = b;
    step();
    btn = 3'b000;
    $display("press btn=%b -> state=%0d input_ok=%0b level=%0d", b, state_code, input_ok, level);
  endtask

  // Follows playback up to WAIT_IN, recording the model's symbol at each GEN
  // and the LED pattern at the start of each SHOW_ON.
  task automatic run_to_wait(input int budget);
    int prev;
    int n;
    prev = -1;
    n    = 0;
    shown.delete();
    while (state_code != 3'd4 && n < budget) begin
      if (state_code == 3'd1) exp_seq.push_back(sym_of(model_lfsr));
      if (state_code == 3'd2 && prev != 2) shown.push_back(led_show);
      prev = int'(state_code);
      step();
      n++;
    end
    chk("reach_wait_in", int'(state_code), 4);
    $display("playback seen %0d colours, level=%0d", shown.size(), level);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cycles;
    int n;

    corners[0] = '{name: "correct", mode: 0, exp_state: 1, exp_lose: 0, exp_ok: 1};
    corners[1] = '{name: "wrong",   mode: 1, exp_state: 6, exp_lose: 1, exp_ok: 0};
    corners[2] = '{name: "timeout", mode: 2, exp_state: 6, exp_lose: 1, exp_ok: 0};
    corners[3] = '{name: "double",  mode: 3, exp_state: 6, exp_lose: 1, exp_ok: 0};

    // Reset and idle: stray button activity must not start anything.
    do_reset();
    btn = 3'b010;
    step();
    btn = 3'b000;
    repeat (9) step();
    chk("idle_state", int'(state_code), 0);
    chk("idle_led", int'(led_show), 0);
    chk("idle_level", int'(level), 0);
    chk("idle_win", int'(win), 0);
    chk("idle_lose", int'(lose), 0);
    chk("idle_ok", int'(input_ok), 0);
    $display("idle check done: state=%0d", state_code);

    // Full game: three rounds replayed correctly ends in WIN.
    base = ok_count;
    exp_seq.delete();
    prev_shown.delete();
    start_game();
    chk("gen_after_start", int'(state_code), 1);
    for (int r = 1; r <= MAX_LEN; r++) begin
      run_to_wait(200);
      chk("round_level", int'(level), r);
      chk("round_shown_count", shown.size(), r);
      for (int i = 0; i < shown.size(); i++) begin
        chk("shown_colour", int'(shown[i]), 1 << exp_seq[i]);
        if (i < prev_shown.size()) chk("prefix_same", int'(shown[i]), int'(prev_shown[i]));
      end
      prev_shown = shown;
      for (int i = 0; i < r; i++) begin
        press((i < shown.size()) ? shown[i] : 3'b000);
        chk("press_ok", int'(input_ok), 1);
        if (i < r - 1) begin
          chk("still_wait_in", int'(state_code), 4);
          step();
        end
      end
      if (r < MAX_LEN) chk("next_round_gen", int'(state_code), 1);
    end
    chk("win_state", int'(state_code), 5);
    chk("win_flag", int'(win), 1);
    chk("win_lose_low", int'(lose), 0);
    chk("win_level", int'(level), 3);
    chk("win_led_dark", int'(led_show), 0);
    repeat (3) step();
    chk("ok_pulses", ok_count - base, 6);
    chk("win_held", int'(state_code), 5);
    chk("win_level_held", int'(level), 3);

    // Round-1 corner cases from the table.
    foreach (corners[k]) begin
      do_reset();
      exp_seq.delete();
      start_game();
      run_to_wait(100);
      case (corners[k].mode)
        0: press(shown[0]);
        1: press({shown[0][1:0], shown[0][2]});
        3: press(3'b011);
        default: begin
          cycles = 0;
          while (state_code == 3'd4 && cycles < 60) begin
            step();
            cycles++;
          end
          chk({corners[k].name, "_cycles"}, cycles, TIMEOUT_CYCLES);
          $display("timeout after %0d cycles in WAIT_IN", cycles);
        end
      endcase
      chk({corners[k].name, "_state"}, int'(state_code), corners[k].exp_state);
      chk({corners[k].name, "_lose"}, int'(lose), corners[k].exp_lose);
      chk({corners[k].name, "_ok"}, int'(input_ok), corners[k].exp_ok);
      chk({corners[k].name, "_level"}, int'(level), 1);
      if (corners[k].exp_lose == 1) begin
        chk({corners[k].name, "_win"}, int'(win), 0);
        repeat (2) step();
        chk({corners[k].name, "_level_held"}, int'(level), 1);
        start_game();
        chk({corners[k].name, "_restart_gen"}, int'(state_code), 1);
        chk({corners[k].name, "_restart_level0"}, int'(level), 0);
        step();
        chk({corners[k].name, "_restart_level1"}, int'(level), 1);
      end
    end

    // Reset in the middle of round-2 playback.
    do_reset();
    exp_seq.delete();
    start_game();
    run_to_wait(100);
    press(shown[0]);
    n = 0;
    while (state_code != 3'd2 && n < 20) begin
      step();
      n++;
    end
    chk("r2_show_on", int'(state_code), 2);
    chk("r2_level", int'(level), 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_state", int'(state_code), 0);
    chk("midreset_led", int'(led_show), 0);
    chk("midreset_level", int'(level), 0);
    $display("mid-playback reset: state=%0d level=%0d", state_code, level);
    step();
    start_game();
    chk("after_reset_gen", int'(state_code), 1);
    step();
    chk("after_reset_show", int'(state_code), 2);
    chk("after_reset_level", int'(level), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
